// File: rtl/egress_fifo_bank.sv
// egress_fifo_bank: four-lane egress buffer capturing non-zero crossbar words into per-lane FIFOs.
// Ports: clk, reset (async, active-high); In0..In3 lane words (0 = idle); pop[3:0] read requests;
//        data_out0..3 registered read data with valid_out[3:0] pulses; empty/full/almost_empty/
//        almost_full[3:0] occupancy flags; pause = |almost_full; err_overflow/err_underflow sticky.
module egress_fifo_bank #(
   parameter int WIDTH     = 10,
   parameter int DEPTH     = 4,
   parameter int AF_THRESH = 3,
   parameter int AE_THRESH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] In0,
   input  logic [WIDTH-1:0] In1,
   input  logic [WIDTH-1:0] In2,
   input  logic [WIDTH-1:0] In3,
   input  logic [3:0]       pop,
   output logic [WIDTH-1:0] data_out0,
   output logic [WIDTH-1:0] data_out1,
   output logic [WIDTH-1:0] data_out2,
   output logic [WIDTH-1:0] data_out3,
   output logic [3:0]       valid_out,
   output logic [3:0]       empty,
   output logic [3:0]       full,
   output logic [3:0]       almost_empty,
   output logic [3:0]       almost_full,
   output logic             pause,
   output logic [3:0]       err_overflow,
   output logic [3:0]       err_underflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [WIDTH-1:0] din  [4];
   logic [WIDTH-1:0] dout [4];
   assign din[0] = In0;
   assign din[1] = In1;
   assign din[2] = In2;
   assign din[3] = In3;
   assign data_out0 = dout[0];
   assign data_out1 = dout[1];
   assign data_out2 = dout[2];
   assign data_out3 = dout[3];
   assign pause = |almost_full;
   for (genvar n = 0; n < 4; n++) begin : g_lane
      logic [WIDTH-1:0] mem [DEPTH];
      logic [WIDTH-1:0] dq;
      logic [AW-1:0]    wp, rp;
      logic [CW-1:0]    cnt;
      logic             v, ovf, udf, do_pop, do_push;
      // a pop on a full lane frees the slot the same-cycle push lands in
      assign do_pop  = pop[n] && cnt != '0;
      assign do_push = din[n] != '0 && (cnt != CW'(DEPTH) || do_pop);
      always_ff @(posedge clk)
         if (do_push) mem[wp] <= din[n];
      always_ff @(posedge clk or posedge reset)
         if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            v   <= 1'b0;
            dq  <= '0;
            ovf <= 1'b0;
            udf <= 1'b0;
         end else begin
            wp  <= wp + AW'(do_push);
            rp  <= rp + AW'(do_pop);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
            v   <= do_pop;
            if (do_pop) dq <= mem[rp];
            if (pop[n] && cnt == '0) udf <= 1'b1;
            if (din[n] != '0 && !do_push) ovf <= 1'b1;
         end
      assign dout[n]          = dq;
      assign valid_out[n]     = v;
      assign err_overflow[n]  = ovf;
      assign err_underflow[n] = udf;
      assign empty[n]         = cnt == '0;
      assign full[n]          = cnt == CW'(DEPTH);
      assign almost_full[n]   = cnt >= CW'(AF_THRESH);
      assign almost_empty[n]  = cnt <= CW'(AE_THRESH);
   end
endmodule

// File: doc/egress_fifo_bank.md
# egress_fifo_bank

Four-lane output buffer stage that sits directly downstream of the transaction-layer crossbar mux. It captures each non-zero 10-bit word arriving on the mux's four destination outputs into a per-lane FIFO. It releases words to the lane consumers on request, and returns per-lane occupancy flags plus an aggregate `pause` back-pressure signal to the upstream arbitration logic.

## Interface
- `WIDTH`, 10, word width; bits [9:8] carry the destination tag and are stored unmodified.
- `DEPTH`, 4, entries per lane FIFO; must be a power of 2, minimum 2.
- `AF_THRESH`, 3, `almost_full[n]` asserts when lane occupancy ≥ `AF_THRESH`.
- `AE_THRESH`, 1, `almost_empty[n]` asserts when lane occupancy ≤ `AE_THRESH`.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `In0`, `In1`, `In2`, `In3` input WIDTH each: lane data from the mux outputs. The value 0 means idle.
- `pop` input 4: bit n requests one word from lane n.
- `data_out0` … `data_out3` output WIDTH each: registered read data per lane.
- `valid_out` output 4: bit n marks `data_out`n as valid for this cycle.
- `empty`, `full`, `almost_empty`, `almost_full` output 4 each: per-lane occupancy flags.
- `pause` output 1: OR of `almost_full[3:0]`; fed back upstream to stall the mux inputs.
- `err_overflow`, `err_underflow` output 4 each: sticky per-lane error flags.

## Operation
- **Storage.** Each lane has a circular buffer of `DEPTH` words, a write pointer, a read pointer, and an occupancy counter of width clog2(DEPTH)+1. Pointers wrap modulo `DEPTH`.
- **Push.** A lane pushes when `In`n ≠ 0 on a rising edge. No separate valid input exists; zero words are never stored.
- **Pop.** A lane pops when `pop[n]` = 1 and the lane is not empty. The head word is loaded into `data_out`n, and `valid_out[n]` = 1 on the following cycle.
- **Valid and data hold.** `valid_out[n]` is a single-cycle pulse per accepted pop. `data_out`n holds its last value while `valid_out[n]` = 0.
- **Simultaneous push and pop, non-empty lane.** Both are accepted and occupancy is unchanged.
- **Simultaneous push and pop, empty lane.** Only the push is accepted; the pop is an underflow. There is no fall-through.
- **Push on full lane.**
  - With an accepted pop in the same cycle: the push is accepted.
  - Without a pop: the word is dropped, pointers and count are unchanged, and `err_overflow[n]` is set.
- **Pop on empty lane.** Ignored, `valid_out[n]` stays 0, and `err_underflow[n]` is set.
- **Error flags.** Sticky until `reset`; there is no other clear.
- **Flag decoding.** All flags are decoded combinationally from the registered occupancy count:
  - `empty` = count 0.
  - `full` = count `DEPTH`.
  - `almost_full` = count ≥ `AF_THRESH`.
  - `almost_empty` = count ≤ `AE_THRESH`.
- **Lane independence.** Lanes operate fully independently; activity on one lane never affects another.

## Timing
- **Reset values.** All data outputs, `valid_out`, `full`, `almost_full`, `pause`, and both error vectors are 0. `empty` = 4'b1111 and `almost_empty` = 4'b1111. Pointers and counts are 0.
- **Reset mid-operation.** Asserting `reset` in any cycle discards all buffered words immediately, without waiting for a clock edge. The first push is accepted on the first rising edge after `reset` is deasserted.
- **Write latency.** A word pushed at edge k is poppable from edge k+1 onward. `empty[n]` falls after edge k.
- **Read latency.** A pop sampled at edge k gives `data_out`n/`valid_out[n]` valid after edge k, for one cycle.
- **Back-pressure.** `pause` follows the count combinationally, so it changes in the same cycle the count changes. Upstream has one cycle of slack: with `AF_THRESH` = `DEPTH`−1, one in-flight word after `pause` rises still fits.
- **Back-to-back pops.** A pop every cycle drains one word per cycle; `valid_out[n]` stays high continuously while words remain.

## Test plan
- **Reset check.** Assert `reset` mid-stream with lane 0 holding 2 words → all outputs take their reset values immediately; after release, `empty` = 4'b1111 and `pop[0]` yields no valid.
- **Single-lane ordering.**
  - Stimulus: push 10'h001, 10'h002, 10'h003 on `In0` over 3 cycles, then `pop[0]` for 3 cycles.
  - Required: `data_out0` = 001, 002, 003 with `valid_out[0]` high for 3 consecutive cycles, and `empty[0]` = 1 after the last pop.
- **Lane 2 fill, overflow, and pause.**
  - Stimulus: push 10'h201–10'h204 on `In2`, then push 10'h205 without a pop.
  - Required: `full[2]` = 1, `pause` = 1 once the count reaches 3, 205 is dropped, `err_overflow` = 4'b0100, and popping returns 201–204 only.
- **Full-lane push/pop.** Lane 3 full, then push 10'h3AA together with `pop[3]` → count stays 4, no overflow, and 10'h3AA is the last word drained.
- **Underflow.** `pop[1]` on an empty lane 1, plus a simultaneous push 10'h155 / `pop[1]` on empty → no `valid_out[1]`, `err_underflow` = 4'b0010, and 155 is stored (count 1).
- **Parallel lanes.** Concurrent pushes of 10'h0FF, 10'h1FF, 10'h2FF, and 10'h3FF on all four lanes, then `pop` = 4'b1111 → all four `valid_out` bits are high in the same cycle with the matching data.
